// File: rtl/fu_div_if.sv
// Issue-side handshake bundle for the iterative divider: start request,
// operation/operands in, result/finish/busy out.
interface fu_div_if #(
    parameter int WIDTH = 32
);
    logic             EN;
    logic [1:0]       op;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [WIDTH-1:0] res;
    logic             finish;
    logic             busy;

    modport master (
        output EN, op, A, B,
        input  res, finish, busy
    );

    modport slave (
        input  EN, op, A, B,
        output res, finish, busy
    );
endinterface

// File: rtl/fu_div_iter.sv
// Restoring radix-2 iterative divider (DIV/DIVU/REM/REMU, RISC-V results).
// Optional FU_DIV_EARLY_OUT_EN: divide-by-zero and signed overflow bypass CALC.
module fu_div_iter #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic     clk,
    input  logic     rst,
    fu_div_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t           state_r;
    logic [CNT_W-1:0] cnt_r;
    logic [1:0]       op_r;
    logic [WIDTH-1:0] quo_r;
    logic [WIDTH-1:0] rem_r;
    logic [WIDTH-1:0] div_r;
    logic             neg_q_r;
    logic             neg_r_r;
    logic [WIDTH-1:0] res_r;
    logic             finish_r;
    logic             busy_r;

    logic             signed_op_s;
    logic             accept_s;
    logic [WIDTH-1:0] a_mag_s;
    logic [WIDTH-1:0] b_mag_s;
    logic [WIDTH-1:0] quo_load_s;
    logic [WIDTH-1:0] rem_load_s;
    state_t           load_state_s;
    logic [WIDTH:0]   shift_s;
    logic [WIDTH:0]   diff_s;
    logic             step_ok_s;
    logic [WIDTH-1:0] quo_fix_s;
    logic [WIDTH-1:0] rem_fix_s;
    logic [WIDTH-1:0] fix_val_s;

    function automatic logic [WIDTH-1:0] neg_f(input logic [WIDTH-1:0] v);
        return ~v + {{(WIDTH-1){1'b0}}, 1'b1};
    endfunction

    // Operand conditioning at accept time; DONE accepts too so EN held high
    // restarts on the very edge IDLE would have been re-entered.
    always_comb begin
        signed_op_s = ~bus.op[0];
        accept_s    = bus.EN && ((state_r == ST_IDLE) || (state_r == ST_DONE));
        a_mag_s     = (signed_op_s && bus.A[WIDTH-1]) ? neg_f(bus.A) : bus.A;
        b_mag_s     = (signed_op_s && bus.B[WIDTH-1]) ? neg_f(bus.B) : bus.B;
`ifdef FU_DIV_EARLY_OUT_EN
        // Preload the magnitudes the full iteration would have produced; FIX
        // then applies its usual sign rules and yields the architectural value.
        if (bus.B == {WIDTH{1'b0}}) begin
            quo_load_s   = {WIDTH{1'b1}};
            rem_load_s   = a_mag_s;
            load_state_s = ST_FIX;
        end else if (signed_op_s && (bus.A == {1'b1, {(WIDTH-1){1'b0}}})
                     && (bus.B == {WIDTH{1'b1}})) begin
            quo_load_s   = a_mag_s;
            rem_load_s   = {WIDTH{1'b0}};
            load_state_s = ST_FIX;
        end else begin
            quo_load_s   = a_mag_s;
            rem_load_s   = {WIDTH{1'b0}};
            load_state_s = ST_CALC;
        end
`else
        quo_load_s   = a_mag_s;
        rem_load_s   = {WIDTH{1'b0}};
        load_state_s = ST_CALC;
`endif
    end

    // One restoring step plus the sign-corrected result selection.
    always_comb begin
        shift_s   = {rem_r, quo_r[WIDTH-1]};
        diff_s    = shift_s - {1'b0, div_r};
        step_ok_s = ~diff_s[WIDTH];
        // A zero divisor must leave the all-ones quotient un-negated.
        quo_fix_s = (neg_q_r && (div_r != {WIDTH{1'b0}})) ? neg_f(quo_r) : quo_r;
        rem_fix_s = neg_r_r ? neg_f(rem_r) : rem_r;
        fix_val_s = op_r[1] ? rem_fix_s : quo_fix_s;
    end

    // Control FSM with the iteration datapath and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r  <= ST_IDLE;
            cnt_r    <= {CNT_W{1'b0}};
            op_r     <= 2'b00;
            quo_r    <= {WIDTH{1'b0}};
            rem_r    <= {WIDTH{1'b0}};
            div_r    <= {WIDTH{1'b0}};
            neg_q_r  <= 1'b0;
            neg_r_r  <= 1'b0;
            res_r    <= {WIDTH{1'b0}};
            finish_r <= 1'b0;
            busy_r   <= 1'b0;
        end else begin
            if (accept_s) begin
                op_r    <= bus.op;
                quo_r   <= quo_load_s;
                rem_r   <= rem_load_s;
                div_r   <= b_mag_s;
                neg_q_r <= signed_op_s & (bus.A[WIDTH-1] ^ bus.B[WIDTH-1]);
                neg_r_r <= signed_op_s & bus.A[WIDTH-1];
                cnt_r   <= {CNT_W{1'b0}};
            end
            case (state_r)
                ST_IDLE: begin
                    finish_r <= 1'b0;
                    if (accept_s) begin
                        state_r <= load_state_s;
                        busy_r  <= 1'b1;
                    end else begin
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                    end
                end
                ST_CALC: begin
                    rem_r <= step_ok_s ? diff_s[WIDTH-1:0] : shift_s[WIDTH-1:0];
                    quo_r <= {quo_r[WIDTH-2:0], step_ok_s};
                    cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                    if (cnt_r == CNT_W'(WIDTH - 1)) begin
                        state_r <= ST_FIX;
                    end else begin
                        state_r <= ST_CALC;
                    end
                end
                ST_FIX: begin
                    res_r    <= fix_val_s;
                    finish_r <= 1'b1;
                    state_r  <= ST_DONE;
                end
                ST_DONE: begin
                    finish_r <= 1'b0;
                    if (accept_s) begin
                        state_r <= load_state_s;
                        busy_r  <= 1'b1;
                    end else begin
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                    end
                end
                default: begin
                    state_r  <= ST_IDLE;
                    finish_r <= 1'b0;
                    busy_r   <= 1'b0;
                end
            endcase
        end
    end

    assign bus.res    = res_r;
    assign bus.finish = finish_r;
    assign bus.busy   = busy_r;

endmodule
